// File: rtl/core_pkg.sv
// Shared core types for the decode stage.
//   alu_opcode_e            - operation handed to execute
//   load_store_func_code    - LSU operation
//   write_back_mux_selector - result source for the register writeback
//   decode_state_e          - decode FSM states
//   OPCODE_*                - RV32 major opcode constants
package core_pkg;

    typedef enum logic [1:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLT} alu_opcode_e;
    typedef enum logic [1:0] {LSU_NONE, LSU_LW, LSU_SW} load_store_func_code;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} write_back_mux_selector;
    typedef enum logic {RUN, FLUSH} decode_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

endpackage

// File: rtl/Register_File.sv
// Architectural register file: two combinational read ports, one write port.
//   clock, reset              - rising-edge clock, async active-low reset
//   rs1_addr_i/rs2_addr_i     - read addresses; x0 always reads 0
//   rs1_data_o/rs2_data_o     - read data
//   we_i/waddr_i/wdata_i      - write port; writes to x0 are dropped
module Register_File #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned IdxW = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IdxW-1:0] rs1_addr_i,
    input  logic [IdxW-1:0] rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            we_i,
    input  logic [IdxW-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/decode_scoreboard.sv
// Busy-bit scoreboard for registers with an outstanding load.
//   clock, reset            - rising-edge clock, async active-low reset
//   set_valid_i/set_addr_i  - mark a register busy (load accepted)
//   clr_valid_i/clr_addr_i  - writeback clears the busy bit
//   rs1_addr_i/rs2_addr_i   - source registers being decoded
//   rs1_busy_o/rs2_busy_o   - source is busy and not cleared this cycle
module decode_scoreboard #(
    parameter int unsigned NREGS = 32,
    localparam int unsigned IdxW = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            set_valid_i,
    input  logic [IdxW-1:0] set_addr_i,
    input  logic            clr_valid_i,
    input  logic [IdxW-1:0] clr_addr_i,
    input  logic [IdxW-1:0] rs1_addr_i,
    input  logic [IdxW-1:0] rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i && clr_addr_i != '0) busy_d[clr_addr_i] = 1'b0;
        // Set is applied last so a same-cycle set and clear leaves the bit set.
        if (set_valid_i && set_addr_i != '0) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy_o = (rs1_addr_i != '0) && busy_q[rs1_addr_i] &&
                        !(clr_valid_i && clr_addr_i == rs1_addr_i);
    assign rs2_busy_o = (rs2_addr_i != '0) && busy_q[rs2_addr_i] &&
                        !(clr_valid_i && clr_addr_i == rs2_addr_i);

endmodule

// File: rtl/pipelined_decode.sv
// Single-stage pipelined RV32 decode with load-use interlock, writeback
// forwarding and JAL redirect/flush.
//   clock, reset                     - rising-edge clock, async active-low reset
//   instr_valid_ip/instr_ready_op    - fetch handshake; instr_data_ip, instr_pc_ip
//   ex_valid_op/ex_ready_ip          - execute handshake plus ex_* decoded fields
//   wb_valid_ip/wb_addr_ip/wb_data_ip - register writeback (also forwarded)
//   redirect_valid_op/redirect_pc_op - one-cycle fetch redirect
// Define DECODE_BRANCH_EN to decode BEQ/BNE and redirect on taken branches.
module pipelined_decode
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREGS        = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    localparam int unsigned IdxW        = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   instr_valid_ip,
    output logic                   instr_ready_op,
    input  logic [31:0]            instr_data_ip,
    input  logic [XLEN-1:0]        instr_pc_ip,
    output logic                   ex_valid_op,
    input  logic                   ex_ready_ip,
    output alu_opcode_e            ex_alu_operator_op,
    output logic [XLEN-1:0]        ex_operand_a_op,
    output logic [XLEN-1:0]        ex_operand_b_op,
    output logic [XLEN-1:0]        ex_store_data_op,
    output logic [IdxW-1:0]        ex_rd_op,
    output logic                   ex_lsu_en_op,
    output load_store_func_code    ex_lsu_operator_op,
    output write_back_mux_selector ex_wb_sel_op,
    input  logic                   wb_valid_ip,
    input  logic [IdxW-1:0]        wb_addr_ip,
    input  logic [XLEN-1:0]        wb_data_ip,
    output logic                   redirect_valid_op,
    output logic [XLEN-1:0]        redirect_pc_op
);

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [IdxW-1:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_j;
    logic [XLEN-1:0] rf_rs1, rf_rs2, op_a, op_b;

    assign opcode = instr_data_ip[6:0];
    assign funct3 = instr_data_ip[14:12];
    assign funct7 = instr_data_ip[31:25];
    assign rd     = instr_data_ip[7 +: IdxW];
    assign rs1    = instr_data_ip[15 +: IdxW];
    assign rs2    = instr_data_ip[20 +: IdxW];
    assign imm_i  = XLEN'($signed(instr_data_ip[31:20]));
    assign imm_s  = XLEN'($signed({instr_data_ip[31:25], instr_data_ip[11:7]}));
    assign imm_j  = XLEN'($signed({instr_data_ip[31], instr_data_ip[19:12], instr_data_ip[20],
                                   instr_data_ip[30:21], 1'b0}));

    Register_File #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clock      (clock),
        .reset      (reset),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rf_rs1),
        .rs2_data_o (rf_rs2),
        .we_i       (wb_valid_ip),
        .waddr_i    (wb_addr_ip),
        .wdata_i    (wb_data_ip)
    );

    // Same-cycle writeback bypasses the register file.
    assign op_a = (rs1 == '0) ? '0 : (wb_valid_ip && wb_addr_ip == rs1) ? wb_data_ip : rf_rs1;
    assign op_b = (rs2 == '0) ? '0 : (wb_valid_ip && wb_addr_ip == rs2) ? wb_data_ip : rf_rs2;

    alu_opcode_e            dec_alu;
    load_store_func_code    dec_lsu_op;
    write_back_mux_selector dec_wb_sel;
    logic [XLEN-1:0]        dec_a, dec_b, dec_store, jump_target;
    logic [IdxW-1:0]        dec_rd;
    logic                   dec_lsu_en, uses_rs1, uses_rs2, is_load, is_jump;

`ifdef DECODE_BRANCH_EN
    logic [XLEN-1:0] imm_b;
    assign imm_b = XLEN'($signed({instr_data_ip[31], instr_data_ip[7], instr_data_ip[30:25],
                                  instr_data_ip[11:8], 1'b0}));
`endif

    always_comb begin
        dec_alu     = ALU_NOP;
        dec_lsu_op  = LSU_NONE;
        dec_wb_sel  = WB_NONE;
        dec_a       = '0;
        dec_b       = '0;
        dec_store   = '0;
        dec_rd      = '0;
        dec_lsu_en  = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        is_load     = 1'b0;
        is_jump     = 1'b0;
        jump_target = '0;
        case (opcode)
            OPCODE_OP: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_alu = ALU_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_alu = ALU_SUB;
                else if (funct3 == 3'b010 && funct7 == 7'b0000000) dec_alu = ALU_SLT;
                if (dec_alu != ALU_NOP) begin
                    dec_a = op_a; dec_b = op_b; dec_rd = rd; dec_wb_sel = WB_ALU;
                    uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                end
            end
            OPCODE_OPIMM: if (funct3 == 3'b000) begin
                dec_alu = ALU_ADD; dec_a = op_a; dec_b = imm_i; dec_rd = rd;
                dec_wb_sel = WB_ALU; uses_rs1 = 1'b1;
            end
            OPCODE_LOAD: if (funct3 == 3'b010) begin
                dec_alu = ALU_ADD; dec_a = op_a; dec_b = imm_i; dec_rd = rd;
                dec_lsu_en = 1'b1; dec_lsu_op = LSU_LW; dec_wb_sel = WB_LSU;
                uses_rs1 = 1'b1; is_load = 1'b1;
            end
            OPCODE_STORE: if (funct3 == 3'b010) begin
                dec_alu = ALU_ADD; dec_a = op_a; dec_b = imm_s; dec_store = op_b;
                dec_lsu_en = 1'b1; dec_lsu_op = LSU_SW; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPCODE_JAL: begin
                dec_alu = ALU_ADD; dec_a = instr_pc_ip; dec_b = XLEN'(4); dec_rd = rd;
                dec_wb_sel = WB_ALU; is_jump = 1'b1; jump_target = instr_pc_ip + imm_j;
            end
`ifdef DECODE_BRANCH_EN
            OPCODE_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                dec_alu = ALU_SUB; dec_a = op_a; dec_b = op_b;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                // funct3[0] turns BEQ into BNE.
                is_jump = (op_a == op_b) ^ funct3[0];
                jump_target = instr_pc_ip + imm_b;
            end
`endif
            default: ;
        endcase
    end

    decode_state_e state_q, state_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic          rs1_busy, rs2_busy, hazard, accept;

    assign hazard = instr_valid_ip && ((uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy));
    // FLUSH swallows fetch slots unconditionally.
    assign instr_ready_op = (state_q == FLUSH) || (!hazard && (!ex_valid_op || ex_ready_ip));
    assign accept = instr_valid_ip && instr_ready_op && (state_q == RUN);

    decode_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .set_valid_i (accept && is_load),
        .set_addr_i  (rd),
        .clr_valid_i (wb_valid_ip),
        .clr_addr_i  (wb_addr_ip),
        .rs1_addr_i  (rs1),
        .rs2_addr_i  (rs2),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            RUN: if (accept && is_jump) begin
                state_d     = FLUSH;
                flush_cnt_d = 2'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (flush_cnt_q == '0) state_d = RUN;
                else                   flush_cnt_d = flush_cnt_q - 2'd1;
            end
        endcase
    end

    logic ex_valid_q, ex_valid_d;
    assign ex_valid_d = accept ? 1'b1 : (ex_ready_ip ? 1'b0 : ex_valid_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q            <= RUN;
            flush_cnt_q        <= '0;
            ex_valid_q         <= 1'b0;
            ex_alu_operator_op <= ALU_NOP;
            ex_operand_a_op    <= '0;
            ex_operand_b_op    <= '0;
            ex_store_data_op   <= '0;
            ex_rd_op           <= '0;
            ex_lsu_en_op       <= 1'b0;
            ex_lsu_operator_op <= LSU_NONE;
            ex_wb_sel_op       <= WB_NONE;
            redirect_valid_op  <= 1'b0;
            redirect_pc_op     <= '0;
        end else begin
            state_q           <= state_d;
            flush_cnt_q       <= flush_cnt_d;
            ex_valid_q        <= ex_valid_d;
            redirect_valid_op <= accept && is_jump;
            if (accept && is_jump) redirect_pc_op <= jump_target;
            if (accept) begin
                ex_alu_operator_op <= dec_alu;
                ex_operand_a_op    <= dec_a;
                ex_operand_b_op    <= dec_b;
                ex_store_data_op   <= dec_store;
                ex_rd_op           <= dec_rd;
                ex_lsu_en_op       <= dec_lsu_en;
                ex_lsu_operator_op <= dec_lsu_op;
                ex_wb_sel_op       <= dec_wb_sel;
            end
        end
    end

    assign ex_valid_op = ex_valid_q;

endmodule

// File: tb/tb_pipelined_decode.sv
// Directed self-checking bench for pipelined_decode (FLUSH_CYCLES = 2).
module tb_pipelined_decode;
    import core_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FC   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic instr_valid_ip = 1'b0, instr_ready_op;
    logic [31:0] instr_data_ip = '0;
    logic [XLEN-1:0] instr_pc_ip = '0;
    logic ex_valid_op, ex_ready_ip = 1'b1;
    alu_opcode_e ex_alu_operator_op;
    logic [XLEN-1:0] ex_operand_a_op, ex_operand_b_op, ex_store_data_op;
    logic [4:0] ex_rd_op;
    logic ex_lsu_en_op;
    load_store_func_code ex_lsu_operator_op;
    write_back_mux_selector ex_wb_sel_op;
    logic wb_valid_ip = 1'b0;
    logic [4:0] wb_addr_ip = '0;
    logic [XLEN-1:0] wb_data_ip = '0;
    logic redirect_valid_op;
    logic [XLEN-1:0] redirect_pc_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipelined_decode #(.XLEN(XLEN), .NREGS(32), .FLUSH_CYCLES(FC)) dut (
        .clock              (clock),
        .reset              (reset),
        .instr_valid_ip     (instr_valid_ip),
        .instr_ready_op     (instr_ready_op),
        .instr_data_ip      (instr_data_ip),
        .instr_pc_ip        (instr_pc_ip),
        .ex_valid_op        (ex_valid_op),
        .ex_ready_ip        (ex_ready_ip),
        .ex_alu_operator_op (ex_alu_operator_op),
        .ex_operand_a_op    (ex_operand_a_op),
        .ex_operand_b_op    (ex_operand_b_op),
        .ex_store_data_op   (ex_store_data_op),
        .ex_rd_op           (ex_rd_op),
        .ex_lsu_en_op       (ex_lsu_en_op),
        .ex_lsu_operator_op (ex_lsu_operator_op),
        .ex_wb_sel_op       (ex_wb_sel_op),
        .wb_valid_ip        (wb_valid_ip),
        .wb_addr_ip         (wb_addr_ip),
        .wb_data_ip         (wb_data_ip),
        .redirect_valid_op  (redirect_valid_op),
        .redirect_pc_op     (redirect_pc_op)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        instr_valid_ip = 1'b1;
        instr_data_ip  = ins;
        instr_pc_ip    = pc;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_valid_ip = v;
        wb_addr_ip  = a;
        wb_data_ip  = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check_eq("rst ex_valid", 64'(ex_valid_op), 64'd0);
        check_eq("rst redirect_valid", 64'(redirect_valid_op), 64'd0);
        check_eq("rst operand_a", 64'(ex_operand_a_op), 64'd0);
        check_eq("rst redirect_pc", 64'(redirect_pc_op), 64'd0);
        reset = 1'b1;

        // ADDI x1,x0,5 then ADD x2,x1,x1 with x1 written back in the ADD cycle
        drive(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), 32'h0);
        #1 check_eq("addi ready", 64'(instr_ready_op), 64'd1);
        tick();
        check_eq("addi ex_valid", 64'(ex_valid_op), 64'd1);
        check_eq("addi alu", 64'(ex_alu_operator_op), 64'(ALU_ADD));
        check_eq("addi b", 64'(ex_operand_b_op), 64'd5);
        drive(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'h4);
        wb(1'b1, 5'd1, 32'd5);
        #1 check_eq("add no stall", 64'(instr_ready_op), 64'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check_eq("add fwd a", 64'(ex_operand_a_op), 64'd5);
        check_eq("add fwd b", 64'(ex_operand_b_op), 64'd5);
        check_eq("add rd", 64'(ex_rd_op), 64'd2);

        // LW x3,0(x0) then dependent ADD x4,x3,x0
        drive(enc_i(12'd0, 5'd0, 3'b010, 5'd3, 7'h03), 32'h8);
        tick();
        check_eq("lw lsu_en", 64'(ex_lsu_en_op), 64'd1);
        check_eq("lw lsu_op", 64'(ex_lsu_operator_op), 64'(LSU_LW));
        check_eq("lw wb_sel", 64'(ex_wb_sel_op), 64'(WB_LSU));
        drive(enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd4), 32'hC);
        #1 check_eq("loaduse stall", 64'(instr_ready_op), 64'd0);
        tick();
        check_eq("loaduse bubble", 64'(ex_valid_op), 64'd0);
        check_eq("loaduse still stall", 64'(instr_ready_op), 64'd0);
        wb(1'b1, 5'd3, 32'h1234);
        #1 check_eq("loaduse release", 64'(instr_ready_op), 64'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check_eq("loaduse ex_valid", 64'(ex_valid_op), 64'd1);
        check_eq("loaduse fwd a", 64'(ex_operand_a_op), 64'h1234);
        check_eq("loaduse rd", 64'(ex_rd_op), 64'd4);

        // SUB x11,x3,x1 reading the register file
        drive(enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd11), 32'h10);
        tick();
        check_eq("sub alu", 64'(ex_alu_operator_op), 64'(ALU_SUB));
        check_eq("sub a", 64'(ex_operand_a_op), 64'h1234);
        check_eq("sub b", 64'(ex_operand_b_op), 64'd5);

        // JAL x1,+16 at 0x100, then FC dropped slots (one is a load)
        drive(enc_j(21'd16, 5'd1), 32'h100);
        tick();
        check_eq("jal redirect_valid", 64'(redirect_valid_op), 64'd1);
        check_eq("jal redirect_pc", 64'(redirect_pc_op), 64'h110);
        check_eq("jal a", 64'(ex_operand_a_op), 64'h100);
        check_eq("jal b", 64'(ex_operand_b_op), 64'd4);
        check_eq("jal wb_sel", 64'(ex_wb_sel_op), 64'(WB_ALU));
        drive(enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'h03), 32'h104);
        #1 check_eq("flush1 ready", 64'(instr_ready_op), 64'd1);
        tick();
        check_eq("flush1 redirect pulse", 64'(redirect_valid_op), 64'd0);
        check_eq("flush1 dropped", 64'(ex_valid_op), 64'd0);
        drive(enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'h13), 32'h108);
        #1 check_eq("flush2 ready", 64'(instr_ready_op), 64'd1);
        tick();
        check_eq("flush2 dropped", 64'(ex_valid_op), 64'd0);
        drive(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd8), 32'h110);
        #1 check_eq("post flush no busy", 64'(instr_ready_op), 64'd1);
        tick();
        check_eq("post flush issue", 64'(ex_valid_op), 64'd1);
        check_eq("post flush rd", 64'(ex_rd_op), 64'd8);

        // Execute back-pressure for 3 cycles
        ex_ready_ip = 1'b0;
        drive(enc_i(12'd3, 5'd0, 3'b000, 5'd9, 7'h13), 32'h114);
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("stall ready", 64'(instr_ready_op), 64'd0);
            tick();
            check_eq("stall ex_valid", 64'(ex_valid_op), 64'd1);
            check_eq("stall rd held", 64'(ex_rd_op), 64'd8);
            check_eq("stall alu held", 64'(ex_alu_operator_op), 64'(ALU_ADD));
        end
        ex_ready_ip = 1'b1;
        #1 check_eq("stall release", 64'(instr_ready_op), 64'd1);
        tick();
        check_eq("after stall rd", 64'(ex_rd_op), 64'd9);
        check_eq("after stall b", 64'(ex_operand_b_op), 64'd3);

        // Reset asserted mid-stall with x3 busy
        drive(enc_i(12'd0, 5'd0, 3'b010, 5'd3, 7'h03), 32'h300);
        tick();
        ex_ready_ip = 1'b0;
        drive(enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd4), 32'h304);
        #1 check_eq("pre-reset stall", 64'(instr_ready_op), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid rst ex_valid", 64'(ex_valid_op), 64'd0);
        check_eq("mid rst lsu_en", 64'(ex_lsu_en_op), 64'd0);
        check_eq("mid rst busy cleared", 64'(instr_ready_op), 64'd1);
        tick();
        reset = 1'b1;
        ex_ready_ip = 1'b1;
        tick();
        check_eq("after rst issue", 64'(ex_valid_op), 64'd1);
        check_eq("after rst rd", 64'(ex_rd_op), 64'd4);

        // Same-cycle set and clear of x12 leaves it busy
        drive(enc_i(12'd0, 5'd0, 3'b010, 5'd12, 7'h03), 32'h400);
        wb(1'b1, 5'd12, 32'h55);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        drive(enc_r(7'h00, 5'd0, 5'd12, 3'b000, 5'd13), 32'h404);
        #1 check_eq("set wins stall", 64'(instr_ready_op), 64'd0);
        wb(1'b1, 5'd12, 32'h77);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check_eq("set wins fwd a", 64'(ex_operand_a_op), 64'h77);

        // Writeback to x0 is ignored
        drive(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd10), 32'h408);
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check_eq("x0 reads zero", 64'(ex_operand_a_op), 64'd0);

        // Unknown opcode issues as a NOP
        drive(32'h0000_057F, 32'h40C);
        tick();
        check_eq("nop alu", 64'(ex_alu_operator_op), 64'(ALU_NOP));
        check_eq("nop wb_sel", 64'(ex_wb_sel_op), 64'(WB_NONE));
        check_eq("nop lsu_en", 64'(ex_lsu_en_op), 64'd0);

        // BEQ x0,x0,+8 at 0x200
        drive(enc_b(13'd8, 5'd0, 5'd0, 3'b000), 32'h200);
        tick();
`ifdef DECODE_BRANCH_EN
        check_eq("beq redirect_valid", 64'(redirect_valid_op), 64'd1);
        check_eq("beq redirect_pc", 64'(redirect_pc_op), 64'h208);
        check_eq("beq alu", 64'(ex_alu_operator_op), 64'(ALU_SUB));
`else
        check_eq("beq no redirect", 64'(redirect_valid_op), 64'd0);
        check_eq("beq alu nop", 64'(ex_alu_operator_op), 64'(ALU_NOP));
`endif
        instr_valid_ip = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
